// File: rtl/hazard_ctrl_pkg.sv
// Shared core constants for hazard control: writeback-source encodings,
// forwarding selects, scoreboard entry layout, FSM states, match helpers.
package hazard_ctrl_pkg;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_IMM  = 2'b11;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b01;
    localparam logic [1:0] FWD_W  = 2'b10;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } sb_ent_t;

    function automatic logic sb_hit(
        input sb_ent_t    ent,
        input logic [4:0] rs
    );
        return ent.wr && (ent.rd != 5'd0) && (ent.rd == rs);
    endfunction

    function automatic logic [1:0] fwd_pick(
        input logic hit_m,
        input logic hit_w
    );
        if (hit_m)
            return FWD_M;
        if (hit_w)
            return FWD_W;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_sb.sv
// Three-entry destination scoreboard (E, M, W) with match logic.
// Ports: D-stage register fields in, bubble_e in; E/M hit flags and E fwd selects out.
module hazard_sb
    import hazard_ctrl_pkg::*;
#(
    parameter logic [1:0] LOAD_SRC = WB_LOAD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rs1_d,
    input  logic [4:0] rs2_d,
    input  logic [4:0] rd_d,
    input  logic       rd_write_d,
    input  logic [1:0] rd_write_src_d,
    input  logic       bubble_e,
    output logic       e_hit_rs1,
    output logic       e_hit_rs2,
    output logic       e_ld,
    output logic       m_hit_rs1,
    output logic       m_hit_rs2,
    output logic [1:0] fwd_rs1_e,
    output logic [1:0] fwd_rs2_e
);

    sb_ent_t    ent_d;
    sb_ent_t    ent_e;
    sb_ent_t    ent_m;
    sb_ent_t    ent_w;
    logic [4:0] rs1_e;
    logic [4:0] rs2_e;

    always_comb begin
        ent_d    = '0;
        ent_d.rd = rd_d;
        ent_d.wr = rd_write_d;
        ent_d.ld = rd_write_d && (rd_write_src_d == LOAD_SRC);
    end

    // E also keeps its source registers so the E-stage
    // forwarding selects can be formed against M and W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_e <= '0;
            ent_m <= '0;
            ent_w <= '0;
            rs1_e <= '0;
            rs2_e <= '0;
        end else begin
            ent_w <= ent_m;
            ent_m <= ent_e;
            if (bubble_e) begin
                ent_e <= '0;
                rs1_e <= '0;
                rs2_e <= '0;
            end else begin
                ent_e <= ent_d;
                rs1_e <= rs1_d;
                rs2_e <= rs2_d;
            end
        end
    end

    assign e_hit_rs1 = sb_hit(ent_e, rs1_d);
    assign e_hit_rs2 = sb_hit(ent_e, rs2_d);
    assign e_ld      = ent_e.ld;
    assign m_hit_rs1 = sb_hit(ent_m, rs1_d);
    assign m_hit_rs2 = sb_hit(ent_m, rs2_d);

    assign fwd_rs1_e = fwd_pick(sb_hit(ent_m, rs1_e),
                                sb_hit(ent_w, rs1_e));
    assign fwd_rs2_e = fwd_pick(sb_hit(ent_m, rs2_e),
                                sb_hit(ent_w, rs2_e));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes, forwarding selects, drain FSM.
// Ports: D-stage fields, branch/taken, fetch valid in; stall/flush/fwd, counters out.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter logic [1:0] LOAD_SRC = WB_LOAD,
    parameter int         CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rd_d,
    input  logic             rd_write_d,
    input  logic [1:0]       rd_write_src_d,
    input  logic             branch,
    input  logic             branch_d,
    input  logic             mem_valid_f,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic             forwarding_rs1_d,
    output logic             forwarding_rs2_d,
    output logic [1:0]       fwd_rs1_e,
    output logic [1:0]       fwd_rs2_e,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_state_t state;

    logic e_hit_rs1;
    logic e_hit_rs2;
    logic e_ld;
    logic m_hit_rs1;
    logic m_hit_rs2;
    logic ld_use;
    logic br_haz;
    logic hazard;

    hazard_sb #(
        .LOAD_SRC(LOAD_SRC)
    ) u_sb (
        .clk           (clk),
        .rst_n         (rst_n),
        .rs1_d         (rs1_d),
        .rs2_d         (rs2_d),
        .rd_d          (rd_d),
        .rd_write_d    (rd_write_d),
        .rd_write_src_d(rd_write_src_d),
        .bubble_e      (flush_e | stall_d),
        .e_hit_rs1     (e_hit_rs1),
        .e_hit_rs2     (e_hit_rs2),
        .e_ld          (e_ld),
        .m_hit_rs1     (m_hit_rs1),
        .m_hit_rs2     (m_hit_rs2),
        .fwd_rs1_e     (fwd_rs1_e),
        .fwd_rs2_e     (fwd_rs2_e)
    );

    assign ld_use = e_ld & (e_hit_rs1 | e_hit_rs2);
    assign br_haz = branch & (m_hit_rs1 | m_hit_rs2);
    assign hazard = ld_use | br_haz;

    // ALU result in E feeds the D-stage comparator directly.
    assign forwarding_rs1_d = rst_n & branch & e_hit_rs1 & ~e_ld;
    assign forwarding_rs2_d = rst_n & branch & e_hit_rs2 & ~e_ld;

    // Outputs are gated by rst_n so nothing escapes while in reset.
    // DRAIN discards the outstanding wrong-path response; otherwise
    // a hazard stall outranks a taken-branch flush, which outranks
    // a fetch-miss bubble.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (rst_n) begin
            if (state == DRAIN) begin
                flush_d = 1'b1;
            end else if (hazard) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end else if (branch_d) begin
                flush_d = 1'b1;
            end else if (!mem_valid_f) begin
                stall_f = 1'b1;
                flush_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            unique case (state)
                RUN: begin
                    if (!hazard && branch_d && !mem_valid_f)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (mem_valid_f)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_d && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_d && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed vector bench for hazard_ctrl.
// Table-driven pipeline sequence plus drain, fetch-miss, reset, saturation cases.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] rs1_d;
    logic [4:0] rs2_d;
    logic [4:0] rd_d;
    logic       rd_write_d;
    logic [1:0] rd_write_src_d;
    logic       branch;
    logic       branch_d;
    logic       mem_valid_f;
    logic       stall_f;
    logic       stall_d;
    logic       flush_d;
    logic       flush_e;
    logic       forwarding_rs1_d;
    logic       forwarding_rs2_d;
    logic [1:0] fwd_rs1_e;
    logic [1:0] fwd_rs2_e;
    logic [3:0] stall_cnt;
    logic [3:0] flush_cnt;

    int n_chk;
    int n_fail;

    hazard_ctrl #(
        .LOAD_SRC(2'b01),
        .CNT_W   (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rs1_d           (rs1_d),
        .rs2_d           (rs2_d),
        .rd_d            (rd_d),
        .rd_write_d      (rd_write_d),
        .rd_write_src_d  (rd_write_src_d),
        .branch          (branch),
        .branch_d        (branch_d),
        .mem_valid_f     (mem_valid_f),
        .stall_f         (stall_f),
        .stall_d         (stall_d),
        .flush_d         (flush_d),
        .flush_e         (flush_e),
        .forwarding_rs1_d(forwarding_rs1_d),
        .forwarding_rs2_d(forwarding_rs2_d),
        .fwd_rs1_e       (fwd_rs1_e),
        .fwd_rs2_e       (fwd_rs2_e),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       wr;
        logic [1:0] src;
        logic       br;
        logic       bd;
        logic       mv;
        logic [5:0] fl;
        logic [1:0] e1;
        logic [1:0] e2;
        logic [3:0] sc;
        logic [3:0] fc;
    } vec_t;

    // fl = {stall_f, stall_d, flush_d, flush_e, fwd_rs1_d, fwd_rs2_d}
    function automatic vec_t mk(
        input logic [4:0] rs1, input logic [4:0] rs2,
        input logic [4:0] rd, input logic wr,
        input logic [1:0] src, input logic br,
        input logic bd, input logic mv,
        input logic [5:0] fl, input logic [1:0] e1,
        input logic [1:0] e2, input int sc, input int fc
    );
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.wr = wr; v.src = src; v.br = br;
        v.bd = bd; v.mv = mv; v.fl = fl;
        v.e1 = e1; v.e2 = e2;
        v.sc = 4'(sc); v.fc = 4'(fc);
        return v;
    endfunction

    task automatic cmp(input string nm, input int id,
                       input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL v%0d.%s got %0h want %0h", id, nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rs1_d          = v.rs1;
        rs2_d          = v.rs2;
        rd_d           = v.rd;
        rd_write_d     = v.wr;
        rd_write_src_d = v.src;
        branch         = v.br;
        branch_d       = v.bd;
        mem_valid_f    = v.mv;
    endtask

    task automatic check(input vec_t v, input int id);
        cmp("stall_f", id, {3'b0, stall_f}, {3'b0, v.fl[5]});
        cmp("stall_d", id, {3'b0, stall_d}, {3'b0, v.fl[4]});
        cmp("flush_d", id, {3'b0, flush_d}, {3'b0, v.fl[3]});
        cmp("flush_e", id, {3'b0, flush_e}, {3'b0, v.fl[2]});
        cmp("fwd1_d", id, {3'b0, forwarding_rs1_d}, {3'b0, v.fl[1]});
        cmp("fwd2_d", id, {3'b0, forwarding_rs2_d}, {3'b0, v.fl[0]});
        cmp("fwd1_e", id, {2'b0, fwd_rs1_e}, {2'b0, v.e1});
        cmp("fwd2_e", id, {2'b0, fwd_rs2_e}, {2'b0, v.e2});
        cmp("stall_cnt", id, stall_cnt, v.sc);
        cmp("flush_cnt", id, flush_cnt, v.fc);
    endtask

    task automatic run(input vec_t v, input int id);
        @(posedge clk);
        #1 drive(v);
        #4 check(v, id);
    endtask

    task automatic nop_in();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        nop_in();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    vec_t tbl[25];
    vec_t z;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        nop_in();
        repeat (2) @(posedge clk);
        #1 mem_valid_f = 1'b0;
        branch_d = 1'b1;
        #1 check(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 99);
        nop_in();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // load-use, ALU forward to branch, load->branch, E fwd, x0, flushes
        tbl[0]  = mk(1, 0, 5, 1, 1, 0, 0, 1, 6'b000000, 0, 0, 0, 0);
        tbl[1]  = mk(5, 1, 6, 1, 0, 0, 0, 1, 6'b110100, 0, 0, 0, 0);
        tbl[2]  = mk(5, 1, 6, 1, 0, 0, 0, 1, 6'b000000, 0, 0, 1, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 2, 0, 1, 0);
        tbl[4]  = mk(2, 3, 5, 1, 0, 0, 0, 1, 6'b000000, 0, 0, 1, 0);
        tbl[5]  = mk(5, 0, 0, 0, 0, 1, 0, 1, 6'b000010, 0, 0, 1, 0);
        tbl[6]  = mk(1, 0, 5, 1, 1, 0, 0, 1, 6'b000000, 1, 0, 1, 0);
        tbl[7]  = mk(5, 6, 0, 0, 0, 1, 0, 1, 6'b110100, 0, 0, 1, 0);
        tbl[8]  = mk(5, 6, 0, 0, 0, 1, 0, 1, 6'b110100, 0, 0, 2, 0);
        tbl[9]  = mk(5, 6, 0, 0, 0, 1, 0, 1, 6'b000000, 0, 0, 3, 0);
        tbl[10] = mk(1, 2, 7, 1, 0, 0, 0, 1, 6'b000000, 0, 0, 3, 0);
        tbl[11] = mk(7, 7, 8, 1, 0, 0, 0, 1, 6'b000000, 0, 0, 3, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 1, 1, 3, 0);
        tbl[13] = mk(1, 0, 0, 1, 0, 0, 0, 1, 6'b000000, 0, 0, 3, 0);
        tbl[14] = mk(0, 0, 9, 1, 0, 0, 0, 1, 6'b000000, 0, 0, 3, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 1, 0, 1, 6'b000000, 0, 0, 3, 0);
        tbl[16] = mk(1, 2, 0, 0, 0, 1, 1, 1, 6'b001000, 0, 0, 3, 0);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 0, 0, 3, 1);
        tbl[18] = mk(1, 0, 10, 1, 1, 0, 0, 1, 6'b000000, 0, 0, 3, 1);
        tbl[19] = mk(10, 0, 0, 0, 0, 1, 1, 1, 6'b110100, 0, 0, 3, 1);
        tbl[20] = mk(10, 0, 0, 0, 0, 1, 1, 1, 6'b110100, 0, 0, 4, 1);
        tbl[21] = mk(10, 0, 0, 0, 0, 1, 1, 1, 6'b001000, 0, 0, 5, 1);
        tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 0, 0, 5, 2);
        tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 6'b101000, 0, 0, 5, 2);
        tbl[24] = mk(0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 0, 0, 5, 3);

        for (int i = 0; i < 25; i++)
            run(tbl[i], i);

        // taken branch with fetch outstanding: drain until first valid
        run(mk(0, 0, 0, 0, 0, 1, 1, 0, 6'b001000, 0, 0, 5, 3), 30);
        run(mk(0, 0, 0, 0, 0, 0, 0, 0, 6'b001000, 0, 0, 5, 4), 31);
        run(mk(0, 0, 0, 0, 0, 0, 0, 0, 6'b001000, 0, 0, 5, 5), 32);
        run(mk(0, 0, 0, 0, 0, 0, 0, 1, 6'b001000, 0, 0, 5, 6), 33);
        run(mk(0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 0, 0, 5, 7), 34);

        // four fetch misses from a clean start
        hold_reset();
        for (int i = 0; i < 4; i++)
            run(mk(0, 0, 0, 0, 0, 0, 0, 0, 6'b101000, 0, 0, 0, i), 40 + i);
        run(mk(0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 0, 0, 0, 4), 44);

        // reset in the middle of a load-use stall
        run(mk(1, 0, 5, 1, 1, 0, 0, 1, 6'b000000, 0, 0, 0, 4), 50);
        run(mk(5, 1, 6, 1, 0, 0, 0, 1, 6'b110100, 0, 0, 0, 4), 51);
        #1 rst_n = 1'b0;
        #1 check(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 52);
        hold_reset();
        run(mk(5, 1, 6, 1, 0, 0, 0, 1, 6'b000000, 0, 0, 0, 0), 53);

        // reset while draining
        run(mk(0, 0, 0, 0, 0, 1, 1, 0, 6'b001000, 0, 0, 0, 0), 54);
        #1 rst_n = 1'b0;
        #1 check(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 55);
        hold_reset();
        run(mk(0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 0, 0, 0, 0), 56);

        // flush counter saturates
        z = mk(0, 0, 0, 0, 0, 0, 0, 0, 6'b101000, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 drive(z);
        end
        run(mk(0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 0, 0, 0, 15), 60);
        run(mk(0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 0, 0, 0, 15), 61);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
